// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle control unit.
// Holds the FSM state encoding, the supported opcodes, the ALU operation
// codes driven on Aluop, the AlUsrcB / PCSource mux encodings and the
// instruction classes produced by mc_op_decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_EXEC_I = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b111;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b011;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_LW  = 3'd0,
    CLS_SW  = 3'd1,
    CLS_R   = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_J   = 3'd4,
    CLS_I   = 3'd5,
    CLS_ILL = 3'd6
  } instrClass_e;

endpackage

// File: rtl/mc_op_decode.sv
// mc_op_decode: combinational opcode classifier.
// Ports:
//   opCode     in  IR[31:26]
//   instrClass out instruction class driving the DECODE dispatch
//   immAluOp   out ALU operation for immediate instructions (add otherwise)
//   legal      out 1 when opCode is one of the supported instructions
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  opCode,
  output instrClass_e instrClass,
  output logic [2:0]  immAluOp,
  output logic        legal
);

  always_comb begin
    instrClass = CLS_ILL;
    immAluOp   = ALU_ADD;
    legal      = 1'b1;
    case (opCode)
      LW:    instrClass = CLS_LW;
      SW:    instrClass = CLS_SW;
      RTYPE: instrClass = CLS_R;
      BEQ:   instrClass = CLS_BEQ;
      J:     instrClass = CLS_J;
      ADDI:  instrClass = CLS_I;
      ANDI: begin
        instrClass = CLS_I;
        immAluOp   = ALU_AND;
      end
      ORI: begin
        instrClass = CLS_I;
        immAluOp   = ALU_OR;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS-style datapath.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opCode          IR[31:26], only looked at in DECODE
//   mem_ready       memory finishes the current access this cycle
//   PCWrite..AlUsrcA, AlUsrcB, PCSource, Aluop  datapath enables/selects
//   illegal_op      one-cycle pulse in TRAP
//   instr_done      one-cycle pulse on the last cycle of an instruction
//   state           current FSM state (debug)
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AlUsrcA,
  output logic [1:0] AlUsrcB,
  output logic [1:0] PCSource,
  output logic [2:0] Aluop,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e      curState;
  logic [2:0]  aluOpReg;
  logic        storeReg;   // remembers lw vs sw past DECODE
  instrClass_e instrClass;
  logic [2:0]  immAluOp;
  logic        legal;

  mc_op_decode uDecode (
    .opCode     (opCode),
    .instrClass (instrClass),
    .immAluOp   (immAluOp),
    .legal      (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= S_FETCH;
      aluOpReg <= 3'b000;
      storeReg <= 1'b0;
    end else begin
      case (curState)
        S_FETCH:  if (mem_ready) curState <= S_DECODE;
        S_DECODE: begin
          aluOpReg <= immAluOp;
          storeReg <= (instrClass == CLS_SW);
          if (!legal) curState <= S_TRAP;
          else begin
            case (instrClass)
              CLS_LW, CLS_SW: curState <= S_MEMADR;
              CLS_R:          curState <= S_EXEC_R;
              CLS_BEQ:        curState <= S_BRANCH;
              CLS_J:          curState <= S_JUMP;
              CLS_I:          curState <= S_EXEC_I;
              default:        curState <= S_TRAP;
            endcase
          end
        end
        S_MEMADR: curState <= storeReg ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) curState <= S_MEMWB;
        S_MEMWR:  if (mem_ready) curState <= S_FETCH;
        S_EXEC_R: curState <= S_RWB;
        S_EXEC_I: curState <= S_IWB;
        default:  curState <= S_FETCH;
      endcase
    end
  end

  assign state = curState;

  // Outputs decode the state register; rst gates them so strobes drop
  // the moment reset rises rather than at the next edge.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemReg      = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    AlUsrcA     = 1'b0;
    AlUsrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    Aluop       = 3'b000;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (curState)
        S_FETCH: begin
          MemRead = 1'b1;
          AlUsrcB = SRCB_FOUR;
          Aluop   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          AlUsrcB = SRCB_IMMSH;
          Aluop   = ALU_ADD;
        end
        S_MEMADR: begin
          AlUsrcA = 1'b1;
          AlUsrcB = SRCB_IMM;
          Aluop   = ALU_ADD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemReg     = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC_R: begin
          AlUsrcA = 1'b1;
          AlUsrcB = SRCB_B;
          Aluop   = ALU_FUNCT;
        end
        S_RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          AlUsrcA     = 1'b1;
          AlUsrcB     = SRCB_B;
          Aluop       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_EXEC_I: begin
          AlUsrcA = 1'b1;
          AlUsrcB = SRCB_IMM;
          Aluop   = aluOpReg;
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          Aluop      = aluOpReg;
          instr_done = 1'b1;
        end
        S_TRAP:  illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized bench for multicycle_control with a
// behavioural model that expands each instruction into its expected
// sequence of (state, mem_ready) steps and the outputs for each step.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opCode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemReg, RegDst, RegWrite, AlUsrcA;
  logic [1:0] AlUsrcB, PCSource;
  logic [2:0] Aluop;
  logic       illegal_op, instr_done;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } step_t;
  step_t stepQ[$];

  logic [18:0] obsVec;
  assign obsVec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemReg, RegDst, RegWrite, AlUsrcA, AlUsrcB, PCSource,
                   Aluop, illegal_op, instr_done};

  multicycle_control dut (
    .clk         (clk),
    .rst         (rst),
    .opCode      (opCode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemReg      (MemReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .AlUsrcA     (AlUsrcA),
    .AlUsrcB     (AlUsrcB),
    .PCSource    (PCSource),
    .Aluop       (Aluop),
    .illegal_op  (illegal_op),
    .instr_done  (instr_done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected output vector for one cycle, written straight from the
  // per-state output lists; imm is the immediate-instruction ALU op.
  function automatic logic [18:0] expOut(input logic [3:0] st, input logic mr,
                                         input logic [2:0] imm);
    logic pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, ill, done;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, ill, done} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      4'd0:  begin mrd = 1; asb = 2'b01; aop = 3'b100; irw = mr; pcw = mr; end
      4'd1:  begin asb = 2'b11; aop = 3'b100; end
      4'd2:  begin asa = 1; asb = 2'b10; aop = 3'b100; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; mreg = 1; done = 1; end
      4'd5:  begin mwr = 1; iord = 1; done = mr; end
      4'd6:  begin asa = 1; aop = 3'b010; end
      4'd7:  begin rw = 1; rdst = 1; done = 1; end
      4'd8:  begin asa = 1; aop = 3'b111; pcwc = 1; pcs = 2'b01; done = 1; end
      4'd9:  begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; aop = imm; end
      4'd11: begin rw = 1; aop = imm; done = 1; end
      4'd12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, mreg, rdst, rw, asa, asb, pcs,
            aop, ill, done};
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expands one instruction into its cycle-by-cycle state sequence.
  // fw = FETCH wait cycles, mw = memory wait cycles in MEMRD/MEMWR.
  task automatic buildSteps(input logic [5:0] opc, input int fw, input int mw);
    stepQ.delete();
    for (int i = 0; i < fw; i++) stepQ.push_back('{4'd0, 1'b0});
    stepQ.push_back('{4'd0, 1'b1});
    stepQ.push_back('{4'd1, rndBit()});
    if (opc == 6'b100011) begin
      stepQ.push_back('{4'd2, rndBit()});
      for (int i = 0; i < mw; i++) stepQ.push_back('{4'd3, 1'b0});
      stepQ.push_back('{4'd3, 1'b1});
      stepQ.push_back('{4'd4, rndBit()});
    end else if (opc == 6'b101011) begin
      stepQ.push_back('{4'd2, rndBit()});
      for (int i = 0; i < mw; i++) stepQ.push_back('{4'd5, 1'b0});
      stepQ.push_back('{4'd5, 1'b1});
    end else if (opc == 6'b000000) begin
      stepQ.push_back('{4'd6, rndBit()});
      stepQ.push_back('{4'd7, rndBit()});
    end else if (opc == 6'b000100) begin
      stepQ.push_back('{4'd8, rndBit()});
    end else if (opc == 6'b000010) begin
      stepQ.push_back('{4'd9, rndBit()});
    end else if (opc == 6'b001000 || opc == 6'b001100 || opc == 6'b001101) begin
      stepQ.push_back('{4'd10, rndBit()});
      stepQ.push_back('{4'd11, rndBit()});
    end else begin
      stepQ.push_back('{4'd12, rndBit()});
    end
  endtask

  // Runs one instruction; if abortIdx >= 0, reset is pulsed mid-cycle at
  // that step and the instruction is abandoned.
  task automatic runInstr(input logic [5:0] opc, input int fw, input int mw,
                          input int abortIdx);
    logic [2:0] imm;
    int dones;
    bit isIllegal;
    imm = (opc == 6'b001100) ? 3'b101 : (opc == 6'b001101) ? 3'b011 : 3'b100;
    buildSteps(opc, fw, mw);
    isIllegal = (stepQ[stepQ.size()-1].st == 4'd12);
    dones = 0;
    for (int k = 0; k < stepQ.size(); k++) begin
      mem_ready = stepQ[k].mr;
      // opCode is garbage except in DECODE, where it must be sampled
      opCode = (stepQ[k].st == 4'd1) ? opc : 6'($urandom);
      @(negedge clk);
      checkVal("state", 32'(state), 32'(stepQ[k].st));
      checkVal("outputs", 32'(obsVec), 32'(expOut(stepQ[k].st, stepQ[k].mr, imm)));
      checkVal("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
      checkVal("pcw_excl", 32'(PCWrite & PCWriteCond), 32'd0);
      dones += int'(instr_done);
      if (k == abortIdx) begin
        #2 rst = 1'b1;
        #1;
        checkVal("abort_outputs", 32'(obsVec), 32'd0);
        checkVal("abort_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        checkVal("abort_hold_outputs", 32'(obsVec), 32'd0);
        checkVal("abort_hold_state", 32'(state), 32'd0);
        rst = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checkVal("done_count", 32'(dones), isIllegal ? 32'd0 : 32'd1);
  endtask

  logic [5:0] legalOps [8];

  initial begin
    legalOps = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                 6'b000010, 6'b001000, 6'b001100, 6'b001101};
    rst = 1'b1;
    mem_ready = 1'b1;
    opCode = 6'b000000;
    #2;
    checkVal("reset_state", 32'(state), 32'd0);
    checkVal("reset_outputs", 32'(obsVec), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_hold_state", 32'(state), 32'd0);
    checkVal("reset_hold_outputs", 32'(obsVec), 32'd0);
    rst = 1'b0;

    // Directed instructions
    runInstr(6'b000000, 0, 0, -1);   // add
    runInstr(6'b100011, 0, 2, -1);   // lw with 2 memory waits
    runInstr(6'b101011, 3, 0, -1);   // sw with 3 fetch waits
    runInstr(6'b000100, 0, 0, -1);   // beq
    runInstr(6'b000010, 0, 0, -1);   // j
    runInstr(6'b001101, 0, 0, -1);   // ori
    runInstr(6'b001100, 1, 0, -1);   // andi
    runInstr(6'b001000, 0, 0, -1);   // addi
    runInstr(6'b111111, 0, 0, -1);   // illegal

    // Reset during MEMWR wait, then a normal instruction
    runInstr(6'b101011, 0, 4, 4);
    runInstr(6'b100011, 1, 1, -1);
    // Reset during MEMRD wait
    runInstr(6'b100011, 0, 3, 5);
    runInstr(6'b000000, 0, 0, -1);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 4) == 0) opc = 6'($urandom);
      else opc = legalOps[$urandom_range(0, 7)];
      runInstr(opc, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-002 SHALL have input opCode (6 bits): IR[31:26] of the currently latched instruction.
REQ-003 SHALL have input mem_ready (1 bit): memory completes the current read or write this cycle.
REQ-004 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemReg, RegDst, RegWrite, AlUsrcA (1 bit each): datapath enables and mux selects.
REQ-005 SHALL have output AlUsrcB (2 bits): 00=B, 01=const 4, 10=sext imm, 11=sext imm<<2.
REQ-006 SHALL have output PCSource (2 bits): 00=ALU result, 01=ALUOut, 10=jump target.
REQ-007 SHALL have output Aluop (3 bits): 100=add, 010=R-type funct, 111=beq subtract, 101=and, 011=or.
REQ-008 SHALL have outputs illegal_op (1 bit), instr_done (1 bit) and state (4 bits, debug).

Function
REQ-009 SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, BRANCH=8, JUMP=9, EXEC_I=10, IWB=11, TRAP=12. Codes 13-15 SHALL go to FETCH.
REQ-010 FETCH SHALL drive MemRead=1, IorD=0, AlUsrcA=0, AlUsrcB=01, Aluop=100, PCSource=00. IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready=1. The FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-011 DECODE SHALL drive AlUsrcA=0, AlUsrcB=11, Aluop=100. It SHALL go to:
- MEMADR for 100011 or 101011
- EXEC_R for 000000
- BRANCH for 000100
- JUMP for 000010
- EXEC_I for 001000, 001100, 001101
- TRAP for any other opcode
REQ-012 MEMADR SHALL drive AlUsrcA=1, AlUsrcB=10, Aluop=100. It SHALL go to MEMRD for lw and MEMWR for sw.
REQ-013 MEMRD SHALL drive MemRead=1, IorD=1 and hold until mem_ready=1, then go to MEMWB.
REQ-014 MEMWB SHALL drive RegWrite=1, RegDst=0, MemReg=1, pulse instr_done, then go to FETCH.
REQ-015 MEMWR SHALL drive MemWrite=1, IorD=1 and hold until mem_ready=1. In that cycle it SHALL pulse instr_done, then go to FETCH.
REQ-016 EXEC_R SHALL drive AlUsrcA=1, AlUsrcB=00, Aluop=010, then go to RWB. RWB SHALL drive RegWrite=1, RegDst=1, MemReg=0, pulse instr_done, then go to FETCH.
REQ-017 BRANCH SHALL drive AlUsrcA=1, AlUsrcB=00, Aluop=111, PCWriteCond=1, PCSource=01, pulse instr_done, then go to FETCH.
REQ-018 JUMP SHALL drive PCWrite=1, PCSource=10, pulse instr_done, then go to FETCH.
REQ-019 EXEC_I SHALL drive AlUsrcA=1 and AlUsrcB=10, with Aluop=100 for addi, 101 for andi, 011 for ori, then go to IWB.
REQ-020 IWB SHALL drive RegWrite=1, RegDst=0, MemReg=0 and hold the EXEC_I Aluop, pulse instr_done, then go to FETCH.
REQ-021 EXEC_I and IWB SHALL use an internal 3-bit register for Aluop, loaded in DECODE.
REQ-022 TRAP SHALL drive illegal_op=1 for exactly one cycle with no PC, register or memory write, then go to FETCH.
REQ-023 Every output not listed for a state SHALL be 0 in that state.
REQ-024 MemRead and MemWrite SHALL never both be 1. PCWrite and PCWriteCond SHALL never both be 1.
REQ-025 Latency SHALL be: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 3, each plus (cycles with mem_ready=0).
REQ-026 opCode SHALL be sampled only in DECODE (for next state and Aluop register). Changes in other states SHALL be ignored.

Reset
REQ-027 When rst rises, state SHALL become FETCH and the Aluop register 000 asynchronously.
REQ-028 While rst=1, all outputs except state SHALL be forced to 0.
REQ-029 rst asserted mid-instruction (including a MEMWR wait) SHALL abort it with no further write strobes.
REQ-030 After rst falls, the first clock edge SHALL start a fresh FETCH.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold the state encodings, opcode constants (RTYPE, LW, SW, BEQ, J, ADDI, ANDI, ORI) and the Aluop and AlUsrcB/PCSource encodings.
REQ-032 One combinational sub-module, mc_op_decode, SHALL map opCode to instruction class, immediate Aluop and a legal flag.
REQ-033 The state register and output logic SHALL live in multicycle_control.

Verification
REQ-034 add (000000), mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 and RegDst=1 in cycle 4; instr_done once.
REQ-035 lw (100011), mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; MemReg=1 with RegWrite in MEMWB.
REQ-036 sw (101011), mem_ready=0 for 3 FETCH cycles -> IRWrite/PCWrite only on the 4th cycle; MemWrite=1 in MEMWR; RegWrite never 1.
REQ-037 beq (000100) -> PCWriteCond=1, Aluop=111, PCSource=01 in cycle 3. j (000010) -> PCWrite=1, PCSource=10 in cycle 3.
REQ-038 ori (001101) -> Aluop=011 in EXEC_I and IWB, RegDst=0. opCode 111111 -> illegal_op one cycle, no write strobes.
REQ-039 rst pulsed in MEMWR wait -> MemWrite drops immediately, state=0; next instruction fetches normally.
